// File: rtl/frame_writer.sv
// Camera byte stream to frame buffer writer.
// Pairs RGB565 bytes into pixels and writes them in raster order.
module frame_writer #(
  parameter int H_SIZE = 320,
  parameter int V_SIZE = 240,
  parameter int AW     = $clog2(H_SIZE * V_SIZE)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          capture_en,
  input  logic          vsync,
  input  logic          href,
  input  logic          pix_valid,
  input  logic [7:0]    pix_byte,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data,
  output logic          frame_done,
  output logic          busy,
  output logic          clip_err
);

  localparam int XW = $clog2(H_SIZE + 1);
  localparam int YW = $clog2(V_SIZE + 1);

  localparam logic [XW-1:0] X_MAX = XW'(H_SIZE);
  localparam logic [YW-1:0] Y_MAX = YW'(V_SIZE);
  localparam logic [AW-1:0] LINE  = AW'(H_SIZE);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  logic [0:0]    r_state;
  logic          r_vsync_d;
  logic          r_href_d;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_phase;
  logic [7:0]    r_hi;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_base;

  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [15:0]   r_wr_data;
  logic          r_frame_done;
  logic          r_busy;
  logic          r_clip_err;

  logic w_vs_fall;
  logic w_vs_rise;
  logic w_hr_fall;
  logic w_take;
  logic w_in_range;

  assign w_vs_fall  = r_vsync_d & ~vsync;
  assign w_vs_rise  = ~r_vsync_d & vsync;
  assign w_hr_fall  = r_href_d & ~href;
  assign w_take     = pix_valid & href;
  assign w_in_range = (r_x < X_MAX) && (r_y < Y_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_vsync_d    <= 1'b0;
      r_href_d     <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_phase      <= 1'b0;
      r_hi         <= '0;
      r_addr       <= '0;
      r_base       <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      r_clip_err   <= 1'b0;
    end else begin
      r_vsync_d    <= vsync;
      r_href_d     <= href;
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_vs_fall && capture_en) begin
            r_state    <= S_ACTIVE;
            r_busy     <= 1'b1;
            r_x        <= '0;
            r_y        <= '0;
            r_phase    <= 1'b0;
            r_addr     <= '0;
            r_base     <= '0;
            r_clip_err <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (w_vs_rise) begin
            // Frame end beats any pixel completing in the same cycle
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
            r_phase      <= 1'b0;
          end else if (w_hr_fall) begin
            r_phase <= 1'b0;
            if (r_x != '0) begin
              r_x <= '0;
              if (r_y < Y_MAX) begin
                r_y    <= r_y + 1'b1;
                r_base <= r_base + LINE;
                r_addr <= r_base + LINE;
              end
            end
          end else if (w_take) begin
            if (!r_phase) begin
              r_hi    <= pix_byte;
              r_phase <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              if (w_in_range) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_addr;
                r_wr_data <= {r_hi, pix_byte};
                r_addr    <= r_addr + 1'b1;
              end else begin
                r_clip_err <= 1'b1;
              end
              if (r_x < X_MAX) begin
                r_x <= r_x + 1'b1;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;
  assign clip_err   = r_clip_err;

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer.
// Scoreboard of expected writes plus spot checks on control outputs.
module tb_frame_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        capture_en;
  logic        vsync;
  logic        href;
  logic        pix_valid;
  logic [7:0]  pix_byte;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [15:0] wr_data;
  logic        frame_done;
  logic        busy;
  logic        clip_err;

  int n_chk = 0;
  int n_err = 0;
  int n_fd  = 0;
  int fd0;
  logic [32:0] exp_q[$];

  frame_writer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .capture_en (capture_en),
    .vsync      (vsync),
    .href       (href),
    .pix_valid  (pix_valid),
    .pix_byte   (pix_byte),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .busy       (busy),
    .clip_err   (clip_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_done) n_fd++;
    if (wr_en) begin
      if (exp_q.size() == 0) chk("unexp_wr", 64'(wr_en), 64'd0);
      else chk("wr", 64'({wr_addr, wr_data}), 64'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input logic [7:0] h, input logic [7:0] l,
                    input bit e, input int addr);
    pix_valid = 1'b1;
    pix_byte  = h;
    tick();
    pix_byte = l;
    tick();
    if (e) exp_q.push_back({17'(addr), h, l});
  endtask

  task automatic send_line(input int npix, input int y,
                           input bit arm, input bit odd);
    href = 1'b1;
    tick();
    for (int i = 0; i < npix; i++) begin
      px(8'(i + y), 8'(i) ^ 8'hC3,
         arm && (i < 320) && (y < 240), y * 320 + i);
    end
    if (odd) begin
      pix_valid = 1'b1;
      pix_byte  = 8'hEE;
      tick();
    end
    pix_valid = 1'b0;
    href      = 1'b0;
    tick();
    tick();
  endtask

  task automatic frame_start();
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    tick();
  endtask

  task automatic frame_end();
    vsync = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    chk({tag, "_addr"}, 64'(wr_addr), 64'd0);
    chk({tag, "_data"}, 64'(wr_data), 64'd0);
    chk({tag, "_fd"}, 64'(frame_done), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_clip"}, 64'(clip_err), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    capture_en = 1'b1;
    vsync      = 1'b1;
    href       = 1'b0;
    pix_valid  = 1'b0;
    pix_byte   = 8'h00;
    tick();
    tick();
    chk_zero("rst");
    reset_n = 1'b1;
    tick();

    // single pixel
    fd0 = n_fd;
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    chk("busy_pre", 64'(busy), 64'd0);
    tick();
    chk("busy_rise", 64'(busy), 64'd1);
    href = 1'b1;
    tick();
    pix_valid = 1'b1;
    pix_byte  = 8'hF8;
    tick();
    pix_byte = 8'h1F;
    tick();
    pix_valid = 1'b0;
    exp_q.push_back({17'd0, 16'hF81F});
    chk("sp_wr_en", 64'(wr_en), 64'd1);
    chk("sp_addr", 64'(wr_addr), 64'd0);
    chk("sp_data", 64'(wr_data), 64'hF81F);
    tick();
    chk("sp_wr_off", 64'(wr_en), 64'd0);
    chk("sp_hold", 64'(wr_data), 64'hF81F);
    href = 1'b0;
    tick();
    tick();
    vsync = 1'b1;
    tick();
    chk("sp_fd", 64'(frame_done), 64'd1);
    chk("sp_busy_fall", 64'(busy), 64'd0);
    tick();
    chk("sp_fd_off", 64'(frame_done), 64'd0);
    chk("sp_clip", 64'(clip_err), 64'd0);
    chk("sp_nfd", 64'(n_fd - fd0), 64'd1);
    chk("sp_pend", 64'(exp_q.size()), 64'd0);

    // overlong first line, full last line, extra line past V_SIZE
    fd0 = n_fd;
    frame_start();
    send_line(330, 0, 1'b1, 1'b0);
    chk("ol_clip", 64'(clip_err), 64'd1);
    chk("ol_busy", 64'(busy), 64'd1);
    for (int y = 1; y < 239; y++) send_line(1, y, 1'b1, 1'b0);
    send_line(320, 239, 1'b1, 1'b0);
    chk("ol_busy_end", 64'(busy), 64'd1);
    send_line(2, 240, 1'b1, 1'b0);
    send_line(2, 241, 1'b1, 1'b0);
    frame_end();
    chk("ol_pend", 64'(exp_q.size()), 64'd0);
    chk("ol_nfd", 64'(n_fd - fd0), 64'd1);
    chk("ol_clip_sticky", 64'(clip_err), 64'd1);

    // odd byte, empty line, single byte line, href fall with byte
    frame_start();
    chk("odd_clip_clr", 64'(clip_err), 64'd0);
    send_line(320, 0, 1'b1, 1'b1);
    href = 1'b1;
    tick();
    href = 1'b0;
    tick();
    tick();
    href = 1'b1;
    tick();
    pix_valid = 1'b1;
    pix_byte  = 8'hAB;
    tick();
    pix_valid = 1'b0;
    href      = 1'b0;
    tick();
    tick();
    href = 1'b1;
    tick();
    px(8'h12, 8'h34, 1'b1, 320);
    href      = 1'b0;
    pix_valid = 1'b1;
    pix_byte  = 8'h55;
    tick();
    pix_valid = 1'b0;
    tick();
    href = 1'b1;
    tick();
    px(8'h66, 8'h77, 1'b1, 640);
    pix_valid = 1'b0;
    href      = 1'b0;
    tick();
    frame_end();
    chk("odd_pend", 64'(exp_q.size()), 64'd0);
    chk("odd_clip", 64'(clip_err), 64'd0);

    // disarmed frame, arm raised mid-frame
    fd0 = n_fd;
    capture_en = 1'b0;
    frame_start();
    chk("dis_busy", 64'(busy), 64'd0);
    send_line(5, 0, 1'b0, 1'b0);
    capture_en = 1'b1;
    send_line(5, 1, 1'b0, 1'b0);
    chk("dis_busy2", 64'(busy), 64'd0);
    frame_end();
    chk("dis_nfd", 64'(n_fd - fd0), 64'd0);

    // reset in the middle of a frame
    frame_start();
    href = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) px(8'(i), 8'(i + 7), 1'b1, i);
    pix_valid = 1'b0;
    tick();
    chk("mr_busy_pre", 64'(busy), 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk_zero("mr");
    tick();
    tick();
    reset_n = 1'b1;
    fd0 = n_fd;
    for (int i = 0; i < 50; i++) px(8'(i), 8'(i), 1'b0, 0);
    pix_valid = 1'b0;
    href      = 1'b0;
    tick();
    tick();
    send_line(3, 1, 1'b0, 1'b0);
    chk("mr_busy_post", 64'(busy), 64'd0);
    frame_end();
    chk("mr_nfd", 64'(n_fd - fd0), 64'd0);
    chk("mr_pend", 64'(exp_q.size()), 64'd0);
    frame_start();
    send_line(2, 0, 1'b1, 1'b0);
    frame_end();
    chk("mr_next_pend", 64'(exp_q.size()), 64'd0);

    // vsync rise with a completing low byte
    fd0 = n_fd;
    frame_start();
    href = 1'b1;
    tick();
    pix_valid = 1'b1;
    pix_byte  = 8'h9A;
    tick();
    pix_byte = 8'hBC;
    vsync    = 1'b1;
    tick();
    pix_valid = 1'b0;
    href      = 1'b0;
    chk("vr_fd", 64'(frame_done), 64'd1);
    chk("vr_wr_en", 64'(wr_en), 64'd0);
    tick();
    tick();
    chk("vr_nfd", 64'(n_fd - fd0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
